multiplier_syn_top: RTL and testbench
=====================================

# multiplier_syn_top

Synthesis top for the FV-encryption polynomial multiplier. It computes negacyclic products c = a·u in Z_(2^QW)[x]/(x^N+1). The a and u operands come from an internal LFSR, so the block runs stand-alone on a board clocked from a PLL. Each product is folded into a signature and a done pulse, which keeps the datapath observable after synthesis. It sits directly under the board/simulation wrapper; the wrapper may leave the outputs unconnected.

## Interface
- N, 16: number of polynomial coefficients (power of two, ≥2)
- QW, 5: coefficient width of a and c; arithmetic is mod 2^QW
- UW, 1: coefficient width of u (unsigned); requires QW+UW ≤ 16
- clk  input  1  system clock (PLL output); all state on rising edge
- locked  input  1  PLL locked; serves as the reset, asynchronous, active-low (locked=0 holds the block in reset)
- done  output  1  one-cycle pulse when a product's signature is valid
- sig  output  QW  XOR fold of all N product coefficients of the last product

## Operation
- Reset (locked=0), asynchronous:
  - lfsr=16'hACE1
  - all a, u, acc registers=0
  - state=LOAD, counter=0
  - done=0, sig=0
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts left; new bit0 = b15^b13^b12^b10.
  - Advances only in LOAD.
- LOAD (N cycles, i=0..N-1):
  - a[i] ← lfsr[QW-1:0]
  - u[i] ← lfsr[QW+UW-1:QW]
  - clear acc[i]
  - Last LOAD cycle → MUL with j=0; the rotating copy r is initialised from the freshly loaded a.
- MUL (N cycles, j=0..N-1):
  - For all k in parallel: acc[k] ← acc[k] + u[j]·r[k] mod 2^QW.
  - Then r rotates negacyclically: r[0] ← −r[N−1] mod 2^QW, and r[k] ← r[k−1] for k ≥ 1.
  - Before step j, r[k] = a[k−j] for k ≥ j and −a[N+k−j] for k < j.
  - So after N steps, acc[k] = Σ_{i+j≡k} ±a[i]·u[j] with sign − on wrap.
- OUT (1 cycle):
  - sig ← acc[0]^…^acc[N−1]
  - done=1
  - Next state is LOAD with counter=0; the LFSR continues, so no reseed.
- Widths:
  - Products u[j]·r[k] are truncated to QW bits.
  - All additions and negations wrap mod 2^QW.
  - u is unsigned.
- sig holds its value until the next OUT.

## Timing
- Period is 2N+1 cycles: N LOAD + N MUL + 1 OUT.
- The first LOAD cycle is the first rising edge with locked=1.
- First done is on cycle 2N+1 (cycle 33 for N=16); subsequent done pulses follow every 2N+1 cycles.
- done is high exactly one cycle per product and is registered.
- sig updates on the same edge that raises done.
- Deassertion of locked is not synchronised internally; it is assumed released on a clean PLL edge.
- locked=0 at any point, including mid-LOAD or mid-MUL:
  - The partial product is discarded and all state returns to reset values immediately.
  - After release, the sequence restarts identically to power-up, with the same LFSR seed and the same first sig.

## Structure
- Shared package holds:
  - LFSR seed (16'hACE1) and tap positions
  - FSM state encoding (LOAD, MUL, OUT)
- One sub-module, poly_mac_negacyclic, contains r, acc, the rotate, the N parallel MACs and the sig fold.
  - Interface: start, load_a, u_j, step, clear.
- The top holds the LFSR, the FSM/counter, and the a/u storage.

## Test plan
- Reset and startup:
  - Stimulus: locked=0 for 22 ns, then 1.
  - Required: done=0 and sig=0 during reset; first done on rising edge 33 after release; done period 33 cycles thereafter.
- Golden model:
  - Stimulus: the bench runs the same LFSR sequence and a negacyclic schoolbook multiply mod 32.
  - Required: sig matches the model for the first 8 products.
- Negacyclic wrap (N=4, QW=5, UW=1, force via hierarchical deposit):
  - Stimulus: a=(1,2,3,4), u=(0,1,0,0).
  - Required: c=(−4,1,2,3) mod 32 = (28,1,2,3); sig=28^1^2^3=28.
- Zero operand:
  - Stimulus: u=0 forced.
  - Required: all acc=0, sig=0.
- Reset mid-MUL:
  - Stimulus: drop locked at cycle 20, release.
  - Required: done stays 0 through the abort; first sig after restart equals the first sig from power-up.
- Truncation:
  - Stimulus: QW=5 with a[i]=31 and u all 1.
  - Required: coefficients wrap mod 32 and match the model.

Source files
------------

// File: rtl/multiplier_syn_pkg.sv
// Shared definitions for the polynomial multiplier synthesis top.
//   LFSR_SEED / LFSR_TAP* : operand generator seed and feedback taps
//   state_t               : sequencer states (LOAD, MUL, OUT)
//   lfsr_next()           : one left shift of the Fibonacci LFSR
package multiplier_syn_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1, expressed as register bit positions
    localparam int LFSR_TAP0 = 15;
    localparam int LFSR_TAP1 = 13;
    localparam int LFSR_TAP2 = 12;
    localparam int LFSR_TAP3 = 10;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
    endfunction

endpackage

// File: rtl/multiplier_syn_if.sv
// Observation bus of the multiplier: product-done pulse and signature.
//   done : one-cycle pulse, signature valid
//   sig  : XOR fold of the last product's coefficients
interface multiplier_syn_if #(
    parameter int QW = 5
);
    logic          done;
    logic [QW-1:0] sig;

    modport master (output done, output sig);
    modport slave  (input  done, input  sig);
endinterface

// File: rtl/multiplier_syn_mac.sv
// Negacyclic multiply-accumulate array for Z_(2^QW)[x]/(x^N+1).
//   clk, rst_n : clock, async active-low reset
//   clear      : zero all accumulators
//   start      : load rotating operand r from load_a
//   load_a     : operand a, all N coefficients
//   step       : one MAC step: acc[k] += u_j * r[k], then rotate r
//   u_j        : current u coefficient
//   fold       : XOR of all accumulators (combinational)
module poly_mac_negacyclic #(
    parameter int N  = 16,
    parameter int QW = 5,
    parameter int UW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [N-1:0][QW-1:0]  load_a,
    input  logic                  step,
    input  logic [UW-1:0]         u_j,
    output logic [QW-1:0]         fold
);

    logic [N-1:0][QW-1:0] r, r_rot;
    logic [N-1:0][QW-1:0] acc, acc_nxt;

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [QW-1:0] prod;
        // truncating both operands to QW bits keeps the product exact mod 2^QW
        assign prod       = QW'(u_j) * r[k];
        assign acc_nxt[k] = acc[k] + prod;
        if (k == 0) begin : g_wrap
            // coefficient leaving x^(N-1) re-enters at x^0 negated (x^N = -1)
            assign r_rot[k] = -r[N-1];
        end else begin : g_shift
            assign r_rot[k] = r[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            acc <= '0;
        end else begin
            if (start)     r <= load_a;
            else if (step) r <= r_rot;
            if (clear)     acc <= '0;
            else if (step) acc <= acc_nxt;
        end
    end

    always_comb begin
        fold = '0;
        for (int k = 0; k < N; k++) fold = fold ^ acc[k];
    end

endmodule

// File: rtl/multiplier_syn_top.sv
// Stand-alone negacyclic polynomial multiplier with LFSR operands.
// Sequence: N LOAD cycles (fill a/u from the LFSR), N MUL steps, 1 OUT
// cycle (register signature and pulse done); repeats every 2N+1 cycles.
//   clk    : PLL clock
//   locked : PLL locked, async active-low reset
//   bus    : done pulse and signature
module multiplier_syn_top
    import multiplier_syn_pkg::*;
#(
    parameter int N  = 16,
    parameter int QW = 5,
    parameter int UW = 1
) (
    input  logic              clk,
    input  logic              locked,
    multiplier_syn_if.master  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [15:0]          lfsr;
    logic [N-1:0][QW-1:0] a_q, a_nxt;
    logic [N-1:0][UW-1:0] u_q;
    logic                 last, clear, start, step;
    logic [QW-1:0]        fold, sig_q;
    logic                 done_q;

    assign last = (cnt == CW'(N-1));

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        case (state)
            ST_LOAD: begin
                clear = 1'b1;
                if (last) begin
                    start     = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                step = 1'b1;
                if (last) state_nxt = ST_OUT;
            end
            ST_OUT:  state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge locked) begin
        if (!locked) state <= ST_LOAD;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge locked) begin
        if (!locked)                      cnt <= '0;
        else if (last || state == ST_OUT) cnt <= '0;
        else                              cnt <= cnt + 1'b1;
    end

    // r is seeded on the last LOAD edge, so it must see the coefficient
    // being written on that same edge
    always_comb begin
        a_nxt      = a_q;
        a_nxt[cnt] = lfsr[QW-1:0];
    end

    always_ff @(posedge clk or negedge locked) begin
        if (!locked) begin
            lfsr <= LFSR_SEED;
            a_q  <= '0;
            u_q  <= '0;
        end else if (state == ST_LOAD) begin
            lfsr     <= lfsr_next(lfsr);
            a_q      <= a_nxt;
            u_q[cnt] <= lfsr[QW+UW-1:QW];
        end
    end

    poly_mac_negacyclic #(.N(N), .QW(QW), .UW(UW)) u_mac (
        .clk    (clk),
        .rst_n  (locked),
        .clear  (clear),
        .start  (start),
        .load_a (a_nxt),
        .step   (step),
        .u_j    (u_q[cnt]),
        .fold   (fold)
    );

    always_ff @(posedge clk or negedge locked) begin
        if (!locked) begin
            done_q <= 1'b0;
            sig_q  <= '0;
        end else begin
            done_q <= (state == ST_OUT);
            if (state == ST_OUT) sig_q <= fold;
        end
    end

    assign bus.done = done_q;
    assign bus.sig  = sig_q;

endmodule

// File: tb/tb_multiplier_syn_top.sv
module tb_multiplier_syn_top;

    localparam int N  = 16;
    localparam int QW = 5;
    localparam int P  = 2 * N + 1;

    logic clk = 1'b0;
    logic locked = 1'b0;
    always #5 clk = ~clk;

    multiplier_syn_if #(.QW(QW)) bus ();

    multiplier_syn_top #(.N(N), .QW(QW), .UW(1)) dut (
        .clk    (clk),
        .locked (locked),
        .bus    (bus)
    );

    // small standalone MAC array for directed operand patterns
    logic           m_rst_n = 1'b0;
    logic           m_clear = 1'b0, m_start = 1'b0, m_step = 1'b0;
    logic [3:0][4:0] m_a = '0;
    logic [0:0]     m_u = '0;
    logic [4:0]     m_fold;

    poly_mac_negacyclic #(.N(4), .QW(5), .UW(1)) mac4 (
        .clk    (clk),
        .rst_n  (m_rst_n),
        .clear  (m_clear),
        .start  (m_start),
        .load_a (m_a),
        .step   (m_step),
        .u_j    (m_u),
        .fold   (m_fold)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_sig [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lfsr_step(input int s);
        return ((s << 1) & 'hFFFF) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1);
    endfunction

    // schoolbook product in Z_32[x]/(x^n+1); returns XOR of coefficients
    function automatic int negacyc(input int n, input int a[16], input int u[16], output int c[16]);
        int s;
        for (int k = 0; k < 16; k++) c[k] = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (i + j < n) c[i+j]   += a[i] * u[j];
                else           c[i+j-n] -= a[i] * u[j];
        s = 0;
        for (int k = 0; k < n; k++) begin
            c[k] = c[k] & 31;
            s = s ^ c[k];
        end
        return s;
    endfunction

    task automatic build_model();
        int l;
        int a[16], u[16], c[16];
        l = 'hACE1;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = l & 31;
                u[i] = (l >> 5) & 1;
                l = lfsr_step(l);
            end
            exp_sig[p] = negacyc(N, a, u, c);
        end
    endtask

    // one full period after release: done only on edge P, sig zero until then
    task automatic run_period(input string tag);
        for (int e = 1; e <= P; e++) begin
            @(posedge clk); #1;
            chk({tag, "_done"}, 32'(bus.done), 32'(e == P));
            chk({tag, "_sig"}, 32'(bus.sig), (e == P) ? 32'(exp_sig[0]) : 32'd0);
        end
    endtask

    task automatic abort_at(input int at);
        @(negedge clk); locked = 1'b1;
        for (int e = 1; e <= at; e++) begin
            @(posedge clk); #1;
            chk("abort_run_done", 32'(bus.done), 32'd0);
        end
        locked = 1'b0;
        #1;
        chk("abort_rst_done", 32'(bus.done), 32'd0);
        chk("abort_rst_sig", 32'(bus.sig), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold_done", 32'(bus.done), 32'd0);
        locked = 1'b1;
        run_period("restart");
        @(negedge clk); locked = 1'b0;
    endtask

    task automatic run_mac(input string tag, input int a[16], input int u[16]);
        int c[16];
        int s;
        s = negacyc(4, a, u, c);
        @(negedge clk); m_clear = 1'b1;
        @(negedge clk); m_clear = 1'b0; m_start = 1'b1;
        for (int k = 0; k < 4; k++) m_a[k] = 5'(a[k]);
        @(negedge clk); m_start = 1'b0; m_step = 1'b1;
        for (int j = 0; j < 4; j++) begin
            m_u = 1'(u[j]);
            @(negedge clk);
        end
        m_step = 1'b0;
        for (int k = 0; k < 4; k++)
            chk({tag, "_c"}, 32'(mac4.acc[k]), 32'(c[k]));
        chk({tag, "_fold"}, 32'(m_fold), 32'(s));
    endtask

    initial begin
        int a[16], u[16];
        logic [31:0] sig_exp;
        build_model();

        // reset and startup
        #10;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sig", 32'(bus.sig), 32'd0);
        #10;
        chk("rst_done2", 32'(bus.done), 32'd0);
        #2 locked = 1'b1; m_rst_n = 1'b1;

        // eight products against the golden model
        sig_exp = 0;
        for (int e = 1; e <= 8 * P; e++) begin
            @(posedge clk); #1;
            chk("done", 32'(bus.done), 32'(e % P == 0));
            if (e % P == 0) sig_exp = 32'(exp_sig[e / P - 1]);
            chk("sig", 32'(bus.sig), sig_exp);
        end
        @(negedge clk); locked = 1'b0;
        #1 chk("rst_sig_again", 32'(bus.sig), 32'd0);

        // abort mid-MUL and at a random point
        abort_at(20);
        abort_at(int'($urandom_range(1, P - 1)));

        // negacyclic wrap: a=(1,2,3,4), u=x -> (28,1,2,3)
        for (int k = 0; k < 16; k++) begin a[k] = 0; u[k] = 0; end
        a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4; u[1] = 1;
        run_mac("wrap", a, u);
        chk("wrap_c0", 32'(mac4.acc[0]), 32'd28);
        chk("wrap_sig", 32'(m_fold), 32'd28);

        // zero operand
        for (int k = 0; k < 4; k++) begin a[k] = int'($urandom_range(0, 31)); u[k] = 0; end
        run_mac("zero", a, u);
        chk("zero_fold", 32'(m_fold), 32'd0);

        // truncation: all a = 31, all u = 1
        for (int k = 0; k < 4; k++) begin a[k] = 31; u[k] = 1; end
        run_mac("trunc", a, u);

        // random operands
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = int'($urandom_range(0, 31));
                u[k] = int'($urandom_range(0, 1));
            end
            run_mac("rand", a, u);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
